shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//   Command sequencer for the 4-bit universal shift register (load/shift-left/shift-right).
//   - Accepts one command per valid/ready handshake.
//   - Drives the register's select1/select0, p_in and serial-input pins for the required
//     number of cycles, then pulses done.
//   - Sits between a requester (FSM/testbench/host) and one shift-register instance.
// PARAMETERS
//   WIDTH  4  data width of the controlled register (p_in width)
//   CNT_W  3  width of shift-count field; max shifts per command = 2**CNT_W-1
// PORTS
//   clk         in   1      single clock; controller logic on posedge
//   rst_n       in   1      asynchronous, active-low reset
//   cmd_valid   in   1      command present
//   cmd_ready   out  1      controller can accept (high only in IDLE)
//   cmd_op      in   2      00 NOP, 01 SHL, 10 SHR, 11 LOAD
//   cmd_cnt     in   CNT_W  number of shift cycles (ignored for LOAD/NOP)
//   cmd_data    in   WIDTH  parallel load value (LOAD only)
//   cmd_fill    in   1      serial bit shifted in on every SHL/SHR cycle
//   abort       in   1      synchronous abort of the command in flight
//   select1     out  1      to shift register
//   select0     out  1      to shift register
//   p_in        out  WIDTH  to shift register parallel input
//   left_in     out  1      to shift register left_shift_inp
//   right_in    out  1      to shift register right_shift_inp
//   busy        out  1      high in LOAD/SHIFT/DONE
//   done        out  1      one-cycle pulse on command completion
// BEHAVIOUR
//   - All outputs registered: Moore outputs from state + captured fields.
//   - Outputs change on posedge. The register samples on negedge, so selects are stable
//     half a cycle before each sample.
//   - Reset (async, rst_n=0):
//     - state=IDLE; select1/select0=00 (hold); p_in=0; left_in=right_in=0.
//     - busy=0; done=0; cmd_ready=1 after release.
//   - Handshake:
//     - Transfer when cmd_valid & cmd_ready at a posedge.
//     - cmd_op/cnt/data/fill are captured at that edge; later input changes are ignored.
//   - States:
//     - IDLE: sel=00, cmd_ready=1. On transfer:
//       - LOAD -> LOAD.
//       - SHL/SHR with cnt!=0 -> SHIFT (remaining=cnt).
//       - NOP, or cnt==0 -> DONE.
//     - LOAD: sel=11, p_in=captured data, exactly one cycle -> DONE.
//     - SHIFT: sel=01 (SHL) or 10 (SHR).
//       - left_in (SHL) or right_in (SHR) = fill; the unused serial pin is 0.
//       - remaining decrements each cycle; when remaining==1 -> DONE.
//       - Exactly cnt cycles with sel active.
//     - DONE: sel=00, done=1 for one cycle, cmd_ready=0 -> IDLE.
//   - Latency, command accepted at edge k:
//     - LOAD: sel=11 in cycle k+1, done in cycle k+2.
//     - SHIFT N: sel active cycles k+1..k+N, done in cycle k+N+1.
//     - NOP / cnt=0: done in cycle k+1, no select activity.
//     - Back-to-back: next accept no earlier than the edge ending DONE (IDLE cycle k+N+2).
//   - cnt > WIDTH is legal: the register fills entirely with cmd_fill; no clamping.
//   - abort=1 at a posedge in LOAD/SHIFT/DONE -> IDLE next cycle.
//     - sel=00 immediately in that cycle; no done pulse.
//     - abort in IDLE has no effect and does not block a simultaneous accept... except:
//       abort has priority only outside IDLE.
//   - abort on the final SHIFT cycle: abort wins, no done.
//   - Reset asserted mid-command: outputs return to reset values asynchronously; the
//     command is lost.
//   - Unused/illegal state encodings recover to IDLE.
// STRUCTURE
//   - Shared package/include shift_ctrl_pkg:
//     - op encodings OP_NOP/OP_SHL/OP_SHR/OP_LOAD.
//     - select encodings SEL_HOLD=00, SEL_SHL=01, SEL_SHR=10, SEL_LOAD=11.
//     - state encodings S_IDLE/S_LOAD/S_SHIFT/S_DONE.
//   - One natural sub-module: shift_cnt_dn.
//     - Loadable CNT_W down-counter with async active-low clear.
//     - Outputs a last flag (value==1).
// TESTING
//   1. Reset: rst_n=0 mid-run -> sel=00, busy=0, done=0, cmd_ready=1 on release.
//   2. LOAD 4'b1010 -> sel=11 one cycle, done at k+2; register p_out=1010.
//   3. From 0000, SHL cnt=3 fill=1 -> exactly 3 cycles sel=01, left_in=1; p_out=0111,
//      done at k+4.
//   4. From 1111, SHR cnt=7 fill=0 (cnt>WIDTH) -> 7 cycles sel=10; p_out=0000; done at k+8.
//   5. SHL cnt=0 and NOP -> done at k+1, no sel activity, p_out unchanged.
//   6. SHR cnt=5, abort in 3rd shift cycle -> sel=00 next cycle, no done; p_out reflects
//      2 or 3 shifts per negedge timing; cmd_ready=1; then LOAD is accepted.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared op, select and state encodings for the shift-register sequencer
package shift_ctrl_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_SHL = 2'b01, OP_SHR = 2'b10, OP_LOAD = 2'b11} op_t;
  typedef enum logic [1:0] {SEL_HOLD = 2'b00, SEL_SHL = 2'b01, SEL_SHR = 2'b10, SEL_LOAD = 2'b11} sel_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_LOAD = 2'b01, S_SHIFT = 2'b10, S_DONE = 2'b11} state_t;
  function automatic sel_t shift_sel(input op_t op);
    return op == OP_SHL ? SEL_SHL : SEL_SHR;
  endfunction
endpackage

// File: rtl/shift_cnt_dn.sv
// shift_cnt_dn: loadable down-counter with async active-low clear and a last (value==1) flag
module shift_cnt_dn #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] q,
  output logic             last
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (load) q <= d;
    else if (en) q <= q - 1'b1;
  assign last = q == CNT_W'(1);
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences load/shift commands onto a universal shift register, pulsing done on completion
module shift_seq_ctrl import shift_ctrl_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic             abort,
  output logic             select1,
  output logic             select0,
  output logic [WIDTH-1:0] p_in,
  output logic             left_in,
  output logic             right_in,
  output logic             busy,
  output logic             done
);
  state_t state, nxt;
  op_t op_q, op_n;
  sel_t sel;
  logic [WIDTH-1:0] data_q, data_n;
  logic fill_q, fill_n, accept, last;
  shift_cnt_dn #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .load(accept), .en(state == S_SHIFT),
    .d(cmd_cnt), .q(), .last(last)
  );
  // Fields seen at the accepting edge feed the registered outputs of the very next cycle
  always_comb begin
    accept = state == S_IDLE && cmd_valid;
    op_n = accept ? op_t'(cmd_op) : op_q;
    data_n = accept ? cmd_data : data_q;
    fill_n = accept ? cmd_fill : fill_q;
    nxt = S_IDLE;
    case (state)
      S_IDLE:  nxt = !accept ? S_IDLE : op_n == OP_LOAD ? S_LOAD :
                     (op_n != OP_NOP && cmd_cnt != '0) ? S_SHIFT : S_DONE;
      S_LOAD:  nxt = abort ? S_IDLE : S_DONE;
      S_SHIFT: nxt = abort ? S_IDLE : last ? S_DONE : S_SHIFT;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      op_q <= OP_NOP;
      data_q <= '0;
      fill_q <= 1'b0;
      sel <= SEL_HOLD;
      p_in <= '0;
      left_in <= 1'b0;
      right_in <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state <= nxt;
      op_q <= op_n;
      data_q <= data_n;
      fill_q <= fill_n;
      sel <= nxt == S_LOAD ? SEL_LOAD : nxt == S_SHIFT ? shift_sel(op_n) : SEL_HOLD;
      p_in <= data_n;
      left_in <= nxt == S_SHIFT && op_n == OP_SHL && fill_n;
      right_in <= nxt == S_SHIFT && op_n == OP_SHR && fill_n;
      busy <= nxt != S_IDLE;
      done <= nxt == S_DONE;
      cmd_ready <= nxt == S_IDLE;
    end
  assign {select1, select0} = sel;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed tests of the sequencer driving a negedge-sampled 4-bit universal shift register
module tb_shift_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_fill = 1'b0, abort = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_cnt = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic cmd_ready, select1, select0, left_in, right_in, busy, done;
  logic [3:0] p_in, p_out;
  int checks = 0, errs = 0;

  shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .abort(abort), .select1(select1), .select0(select0), .p_in(p_in),
    .left_in(left_in), .right_in(right_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // The controlled register: left shift enters at bit 0, right shift enters at bit 3
  always @(negedge clk)
    case ({select1, select0})
      2'b01: p_out <= {p_out[2:0], left_in};
      2'b10: p_out <= {right_in, p_out[3:1]};
      2'b11: p_out <= p_in;
      default: p_out <= p_out;
    endcase

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data, input logic fill);
    cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_fill = fill; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic load_reg(input logic [3:0] v);
    send(2'b11, 3'd0, v, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({select1, select0} !== 2'b00) begin errs++; $display("FAIL reset_sel: got %b want 00", {select1, select0}); end
    checks++; if ({busy, done, left_in, right_in} !== 4'b0000) begin errs++; $display("FAIL reset_flags: got %b want 0000", {busy, done, left_in, right_in}); end
    checks++; if (p_in !== 4'h0) begin errs++; $display("FAIL reset_p_in: got %h want 0", p_in); end
    #10 rst_n = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_load();
    send(2'b11, 3'd0, 4'b1010, 1'b0);
    checks++; if ({select1, select0} !== 2'b11) begin errs++; $display("FAIL load_sel: got %b want 11", {select1, select0}); end
    checks++; if (p_in !== 4'b1010) begin errs++; $display("FAIL load_p_in: got %b want 1010", p_in); end
    checks++; if ({busy, done, cmd_ready} !== 3'b100) begin errs++; $display("FAIL load_flags: got %b want 100", {busy, done, cmd_ready}); end
    tick();
    checks++; if ({select1, select0, done} !== 3'b001) begin errs++; $display("FAIL load_done: got %b want 001", {select1, select0, done}); end
    checks++; if (p_out !== 4'b1010) begin errs++; $display("FAIL load_p_out: got %b want 1010", p_out); end
    tick();
    checks++; if ({done, busy, cmd_ready} !== 3'b001) begin errs++; $display("FAIL load_idle: got %b want 001", {done, busy, cmd_ready}); end
  endtask

  task automatic test_shl();
    int n = 0;
    load_reg(4'b0000);
    send(2'b01, 3'd3, 4'hf, 1'b1);
    while ({select1, select0} == 2'b01 && n < 20) begin
      checks++; if ({left_in, right_in} !== 2'b10) begin errs++; $display("FAIL shl_serial: got %b want 10", {left_in, right_in}); end
      n++;
      tick();
    end
    checks++; if (n != 3) begin errs++; $display("FAIL shl_cycles: got %0d want 3", n); end
    checks++; if ({select1, select0, done} !== 3'b001) begin errs++; $display("FAIL shl_done: got %b want 001", {select1, select0, done}); end
    checks++; if (p_out !== 4'b0111) begin errs++; $display("FAIL shl_p_out: got %b want 0111", p_out); end
  endtask

  task automatic test_shr_long();
    int n = 0;
    tick();
    load_reg(4'b1111);
    send(2'b10, 3'd7, 4'h0, 1'b0);
    while ({select1, select0} == 2'b10 && n < 20) begin
      n++;
      tick();
    end
    checks++; if (n != 7) begin errs++; $display("FAIL shr7_cycles: got %0d want 7", n); end
    checks++; if (done !== 1'b1) begin errs++; $display("FAIL shr7_done: got %b want 1", done); end
    checks++; if (p_out !== 4'b0000) begin errs++; $display("FAIL shr7_p_out: got %b want 0000", p_out); end
    tick();
  endtask

  task automatic test_zero();
    load_reg(4'b0110);
    send(2'b01, 3'd0, 4'h9, 1'b1);
    checks++; if ({select1, select0, done, busy} !== 4'b0011) begin errs++; $display("FAIL cnt0: got %b want 0011", {select1, select0, done, busy}); end
    tick();
    send(2'b00, 3'd5, 4'h9, 1'b1);
    checks++; if ({select1, select0, done, busy} !== 4'b0011) begin errs++; $display("FAIL nop: got %b want 0011", {select1, select0, done, busy}); end
    tick();
    checks++; if ({p_out, cmd_ready, done} !== 6'b0110_10) begin errs++; $display("FAIL nop_after: got %b want 011010", {p_out, cmd_ready, done}); end
  endtask

  task automatic test_abort();
    load_reg(4'b1111);
    send(2'b10, 3'd5, 4'h0, 1'b0);
    tick();
    tick();
    checks++; if ({select1, select0} !== 2'b10) begin errs++; $display("FAIL abort_pre: got %b want 10", {select1, select0}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({select1, select0, done, busy, cmd_ready} !== 5'b00001) begin errs++; $display("FAIL abort_idle: got %b want 00001", {select1, select0, done, busy, cmd_ready}); end
    checks++; if (p_out !== 4'b0001) begin errs++; $display("FAIL abort_p_out: got %b want 0001", p_out); end
    abort = 1'b1;
    send(2'b11, 3'd0, 4'b1100, 1'b0);
    abort = 1'b0;
    checks++; if ({select1, select0, p_in} !== 6'b11_1100) begin errs++; $display("FAIL abort_then_load: got %b want 111100", {select1, select0, p_in}); end
    tick();
    tick();
    send(2'b01, 3'd2, 4'h0, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({select1, select0, done, cmd_ready} !== 4'b0001) begin errs++; $display("FAIL abort_final: got %b want 0001", {select1, select0, done, cmd_ready}); end
    tick();
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL abort_no_done: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    load_reg(4'b0000);
    send(2'b11, 3'd0, 4'b0101, 1'b0);
    cmd_op = 2'b01; cmd_cnt = 3'd1; cmd_data = 4'b1110; cmd_fill = 1'b1; cmd_valid = 1'b1;
    checks++; if (p_in !== 4'b0101) begin errs++; $display("FAIL b2b_captured: got %b want 0101", p_in); end
    tick();
    checks++; if ({done, cmd_ready} !== 2'b10) begin errs++; $display("FAIL b2b_done: got %b want 10", {done, cmd_ready}); end
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++; if ({select1, select0, left_in} !== 3'b011) begin errs++; $display("FAIL b2b_shift: got %b want 011", {select1, select0, left_in}); end
    tick();
    checks++; if ({done, p_out} !== 5'b1_1011) begin errs++; $display("FAIL b2b_result: got %b want 11011", {done, p_out}); end
    tick();
  endtask

  task automatic test_reset_mid();
    send(2'b01, 3'd5, 4'h0, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({select1, select0, busy, done, left_in} !== 5'b00000) begin errs++; $display("FAIL midreset_out: got %b want 00000", {select1, select0, busy, done, left_in}); end
    #2 rst_n = 1'b1;
    tick();
    checks++; if ({cmd_ready, busy, select1, select0} !== 4'b1000) begin errs++; $display("FAIL midreset_release: got %b want 1000", {cmd_ready, busy, select1, select0}); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shl();
    test_shr_long();
    test_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
